// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard frame receiver with a scancode FIFO and a small register slave.
//   Optional build macro PS2_PARITY_CHECK_EN enables odd-parity checking and status bit6.
//   Ports:
//     clk, reset_n      single clock, asynchronous active-low reset
//     kc, kd            PS/2 clock and data pins (asynchronous)
//     s_cs_n, s_address slave select (active low), register select 0 = data, 1 = status
//     s_read, s_write   read strobe (pops data register), write strobe (clears status flags)
//     s_writedata       write data, ignored
//     s_readdata        combinational read data
//     irq               registered level interrupt: FIFO non-empty or any flag set
module ps2_scancode_rx #(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       kc,
   input  logic       kd,
   input  logic       s_cs_n,
   input  logic       s_address,
   input  logic       s_read,
   input  logic       s_write,
   input  logic [7:0] s_writedata,
   output logic [7:0] s_readdata,
   output logic       irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t        r_state;
   logic [1:0]    r_kc_sync, r_kd_sync;
   logic          r_kc_prev;
   logic [7:0]    r_shift;
   logic [2:0]    r_bitcnt;
   logic [TW-1:0] r_to;
   logic          r_push, r_frm_evt;
   logic [7:0]    r_push_data;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [3:0]    r_cnt;
   logic          r_ovf, r_frm, r_irq;
   logic          w_fall, w_kd, w_par_ok, w_perr;
   logic          w_full, w_empty, w_push, w_pop, w_clr;
   logic          w_unused;

   assign w_unused = ^s_writedata;
   assign w_fall   = r_kc_prev & ~r_kc_sync[1];
   assign w_kd     = r_kd_sync[1];

`ifdef PS2_PARITY_CHECK_EN
   logic r_par, r_par_evt, r_perr;
   // odd parity: data bits plus parity bit must contain an odd number of ones
   assign w_par_ok = ^{r_shift, r_par};
   assign w_perr   = r_perr;
`else
   assign w_par_ok = 1'b1;
   assign w_perr   = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_kc_sync <= 2'b11;
         r_kd_sync <= 2'b11;
         r_kc_prev <= 1'b1;
      end else begin
         r_kc_sync <= {r_kc_sync[0], kc};
         r_kd_sync <= {r_kd_sync[0], kd};
         r_kc_prev <= r_kc_sync[1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_bitcnt    <= '0;
         r_to        <= '0;
         r_push      <= 1'b0;
         r_push_data <= '0;
         r_frm_evt   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         r_par       <= 1'b0;
         r_par_evt   <= 1'b0;
`endif
      end else begin
         r_push    <= 1'b0;
         r_frm_evt <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         r_par_evt <= 1'b0;
`endif
         // idle-time counter restarts on every kc falling edge and only runs mid-frame
         r_to <= (r_state == IDLE || w_fall) ? '0 : r_to + TW'(1);
         if (r_state != IDLE && !w_fall && r_to == TW'(TIMEOUT_CYCLES - 1)) begin
            r_state   <= IDLE;
            r_bitcnt  <= '0;
            r_to      <= '0;
            r_frm_evt <= 1'b1;
         end else if (w_fall) begin
            case (r_state)
               IDLE: begin
                  if (!w_kd) r_state <= DATA;
                  r_bitcnt <= '0;
               end
               DATA: begin
                  r_shift  <= {w_kd, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) r_state <= PARITY;
               end
               PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                  r_par   <= w_kd;
`endif
                  r_state <= STOP;
               end
               STOP: begin
                  r_state     <= IDLE;
                  r_push      <= w_kd & w_par_ok;
                  r_push_data <= r_shift;
                  r_frm_evt   <= ~w_kd;
`ifdef PS2_PARITY_CHECK_EN
                  r_par_evt   <= ~w_par_ok;
`endif
               end
            endcase
         end
      end
   end

   assign w_full  = r_cnt == 4'(FIFO_DEPTH);
   assign w_empty = r_cnt == 4'd0;
   assign w_push  = r_push & ~w_full;
   assign w_pop   = ~s_cs_n & s_read & ~s_address & ~w_empty;
   assign w_clr   = ~s_cs_n & s_write & s_address;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= r_push_data;
   end

   // flag set pulses take priority over a same-cycle clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_frm <= 1'b0;
         r_irq <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         r_perr <= 1'b0;
`endif
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + {3'b0, w_push} - {3'b0, w_pop};
         r_ovf <= (r_push & w_full) | (r_ovf & ~w_clr);
         r_frm <= r_frm_evt | (r_frm & ~w_clr);
`ifdef PS2_PARITY_CHECK_EN
         r_perr <= r_par_evt | (r_perr & ~w_clr);
`endif
         r_irq <= ~w_empty | r_ovf | r_frm | w_perr;
      end
   end

   assign s_readdata = s_address ? {r_ovf, w_perr, r_frm, 1'b0, r_cnt}
                                 : (w_empty ? 8'h00 : r_mem[r_rp]);
   assign irq        = r_irq;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: randomized PS/2 frames checked against a queue-based model, plus directed cases.
module tb_ps2_scancode_rx;
   localparam int DEPTH = 8;
   localparam int TO    = 300;
   localparam int H     = 20;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PCHK = 1'b1;
`else
   localparam bit PCHK = 1'b0;
`endif

   logic       clk = 1'b0, reset_n = 1'b0, kc = 1'b1, kd = 1'b1;
   logic       s_cs_n = 1'b1, s_address = 1'b1, s_read = 1'b0, s_write = 1'b0;
   logic [7:0] s_writedata = 8'h00;
   logic [7:0] s_readdata;
   logic       irq;

   always #5 clk = ~clk;

   ps2_scancode_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n), .kc(kc), .kd(kd), .s_cs_n(s_cs_n),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq)
   );

   int         n_chk = 0, n_err = 0;
   logic [7:0] q[$];
   bit         m_ovf = 0, m_par = 0, m_frm = 0, chk_en = 0;
   int         gen = 0;
   logic [7:0] got;

   function automatic logic [7:0] m_status();
      return {m_ovf, m_par, m_frm, 1'b0, 4'(q.size())};
   endfunction

   function automatic logic m_irq();
      return q.size() != 0 || m_ovf || m_par || m_frm;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ps2_bit(input bit b);
      kd = b;
      cyc(H);
      kc = 1'b0;
      cyc(H);
      kc = 1'b1;
   endtask

   task automatic m_frame(input logic [7:0] d, input bit p, input bit s);
      bit pok;
      pok = !PCHK || ((^d) ^ p);
      if (!s) m_frm = 1;
      if (PCHK && !pok) m_par = 1;
      if (s && pok) begin
         if (q.size() == DEPTH) m_ovf = 1;
         else q.push_back(d);
      end
      gen++;
   endtask

   task automatic frame(input logic [7:0] d, input bit p, input bit s);
      chk_en = 0;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(p);
      ps2_bit(s);
      cyc(H);
      m_frame(d, p, s);
      chk_en = 1;
   endtask

   task automatic partial(input int nedges);
      chk_en = 0;
      ps2_bit(1'b0);
      for (int i = 1; i < nedges; i++) ps2_bit(1'($urandom_range(0, 1)));
      cyc(TO + 2 * H);
      m_frm = 1;
      gen++;
      chk_en = 1;
   endtask

   task automatic do_read(output logic [7:0] val);
      s_cs_n = 0; s_read = 1; s_address = 0;
      #1 val = s_readdata;
      cyc(1);
      if (q.size() != 0) void'(q.pop_front());
      gen++;
      s_cs_n = 1; s_read = 0; s_address = 1;
   endtask

   task automatic clr_flags();
      s_cs_n = 0; s_write = 1; s_address = 1; s_writedata = 8'($urandom);
      cyc(1);
      m_ovf = 0; m_par = 0; m_frm = 0;
      gen++;
      s_cs_n = 1; s_write = 0;
   endtask

   task automatic status_lit(input string name, input logic [7:0] exp);
      s_address = 1;
      #1 check(name, s_readdata, exp);
      check({name, "_model"}, m_status(), exp);
   endtask

   initial begin
      fork
         begin : cmp
            int last_gen = 0;
            int stable = 0;
            forever begin
               @(negedge clk);
               if (gen != last_gen) stable = 0;
               else stable++;
               last_gen = gen;
               if (reset_n && chk_en) begin
                  check("cmp_readdata", s_readdata,
                        s_address ? m_status() : (q.size() != 0 ? q[0] : 8'h00));
                  if (stable >= 2) check("cmp_irq", {7'b0, irq}, {7'b0, m_irq()});
               end
            end
         end
      join_none

      cyc(3);
      reset_n = 1;
      cyc(2);
      status_lit("reset_status", 8'h00);
      check("reset_irq", {7'b0, irq}, 8'h00);
      s_address = 0;
      #1 check("reset_data", s_readdata, 8'h00);
      s_address = 1;
      chk_en = 1;

      frame(8'h1C, 1'b0, 1'b1);
      status_lit("valid_status", 8'h01);
      check("valid_irq", {7'b0, irq}, 8'h01);
      do_read(got);
      check("valid_data", got, 8'h1C);
      check("valid_irq_hold", {7'b0, irq}, 8'h01);
      status_lit("valid_status_empty", 8'h00);
      cyc(1);
      check("valid_irq_fall", {7'b0, irq}, 8'h00);

      frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
      status_lit("badpar_status", 8'h40);
      check("badpar_irq", {7'b0, irq}, 8'h01);
      clr_flags();
`else
      status_lit("badpar_status", 8'h01);
      do_read(got);
      check("badpar_data", got, 8'h1C);
`endif
      cyc(2);

      for (int i = 1; i <= 9; i++) frame(8'(i), ~^(8'(i)), 1'b1);
      status_lit("ovf_status", 8'h88);
      for (int i = 1; i <= 8; i++) begin
         do_read(got);
         check("ovf_data", got, 8'(i));
      end
      do_read(got);
      check("ovf_empty_data", got, 8'h00);
      clr_flags();
      cyc(2);
      status_lit("ovf_cleared", 8'h00);

      partial(5);
      status_lit("timeout_status", 8'h20);
      frame(8'hF0, 1'b1, 1'b1);
      status_lit("after_timeout_status", 8'h21);
      do_read(got);
      check("after_timeout_data", got, 8'hF0);
      clr_flags();

      frame(8'h1C, 1'b0, 1'b1);
      chk_en = 0;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(1'((8'h5A >> i) & 8'h01));
      ps2_bit(1'b1);
      kd = 1;
      cyc(H);
      kc = 0;
      cyc(3);
      s_cs_n = 0; s_read = 1; s_address = 0;
      #1 got = s_readdata;
      check("pushpop_head", got, 8'h1C);
      cyc(1);
      s_cs_n = 1; s_read = 0; s_address = 1;
      #1 check("pushpop_count", s_readdata, 8'h01);
      cyc(H);
      kc = 1;
      cyc(H);
      void'(q.pop_front());
      q.push_back(8'h5A);
      gen++;
      chk_en = 1;
      do_read(got);
      check("pushpop_next", got, 8'h5A);

      frame(8'h44, ~^(8'h44), 1'b1);
      frame(8'h33, ~^(8'h33), 1'b0);
      chk_en = 0;
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
      reset_n = 0;
      q.delete();
      m_ovf = 0; m_par = 0; m_frm = 0;
      cyc(2);
      status_lit("rst_mid_status", 8'h00);
      check("rst_mid_irq", {7'b0, irq}, 8'h00);
      s_address = 0;
      #1 check("rst_mid_data", s_readdata, 8'h00);
      s_address = 1;
      reset_n = 1;
      cyc(2);
      gen++;
      chk_en = 1;
      frame(8'h29, ~^(8'h29), 1'b1);
      status_lit("rst_after_status", 8'h01);
      do_read(got);
      check("rst_after_data", got, 8'h29);

      for (int n = 0; n < 50; n++) begin
         logic [7:0] d;
         int r;
         d = 8'($urandom);
         r = $urandom_range(0, 9);
         if (r <= 3) frame(d, ~^d, 1'b1);
         else if (r == 4) frame(d, ^d, 1'b1);
         else if (r == 5) frame(d, ~^d, 1'b0);
         else if (r <= 7) do_read(got);
         else if (r == 8) clr_flags();
         else partial($urandom_range(1, 10));
         cyc($urandom_range(1, 4));
      end

      cyc(4);
      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
